lsu_mem_ctrl: RTL and testbench

Load/store unit for the MEM stage. It is the producer side of the write-back load path: it takes load/store requests from the pipeline and runs them on a variable-latency data-memory bus with a req/ack handshake. Loads are aligned and sign/zero-extended, then delivered as o_ld_data to the write-back selector. The pipeline is stalled while an access is in flight.

---
 rtl/lsu_mem_ctrl_if.sv | 21 ++
 rtl/lsu_mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory bus between the load/store unit and memory.
// Uses a req/ack handshake; read data is valid in the ack cycle.
interface lsu_mem_ctrl_if;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
    input  i_mem_ack, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
    output i_mem_ack, i_mem_rdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store unit: legality check, store formatting, and a bus access with timeout.
// Also performs load extraction, and stalls the pipeline while an access is outstanding.
module lsu_mem_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lsu_req,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  output logic        o_lsu_busy,
  output logic        o_ld_valid,
  output logic [31:0] o_ld_data,
  output logic        o_lsu_err,
  lsu_mem_ctrl_if.master mem
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nx;
  logic [7:0]  wait_cnt;
  logic [29:0] addr_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [3:0]  bmask_q;
  logic        err_q;
  logic [31:0] ld_data_q;

  logic        legal;
  logic [3:0]  st_bmask;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        busy_c;
  logic        timeout;

  assign timeout = (wait_cnt == 8'(MAX_WAIT - 1));

  always_comb begin
    legal = 1'b1;
    case (i_funct3)
      3'b000, 3'b100: ;
      3'b001, 3'b101: if (i_lsu_addr[0]) legal = 1'b0;
      3'b010:         if (i_lsu_addr[1:0] != 2'b00) legal = 1'b0;
      default:        legal = 1'b0;
    endcase
    if (i_lsu_wren && i_funct3[2]) legal = 1'b0;
  end

  always_comb begin
    st_bmask = 4'b1111;
    st_wdata = i_st_data;
    if (i_lsu_wren) begin
      case (i_funct3[1:0])
        2'b00: begin
          st_bmask = 4'b0001 << i_lsu_addr[1:0];
          st_wdata = {4{i_st_data[7:0]}};
        end
        2'b01: begin
          st_bmask = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{i_st_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Extraction works on the raw bus data in the ack cycle, so the result is registered only once.
  always_comb begin
    ld_byte = mem.i_mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = mem.i_mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_ext = mem.i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy_c   = 1'b0;
    case (state)
      IDLE: begin
        busy_c = i_lsu_req;
        if (i_lsu_req) state_nx = legal ? ACCESS : RESP;
      end
      ACCESS: begin
        busy_c = 1'b1;
        if (mem.i_mem_ack || timeout) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt  <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      off_q     <= '0;
      wdata_q   <= '0;
      bmask_q   <= '0;
      err_q     <= 1'b0;
      ld_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_lsu_req) begin
            if (legal) begin
              addr_q   <= i_lsu_addr[31:2];
              we_q     <= i_lsu_wren;
              size_q   <= i_funct3[1:0];
              uns_q    <= i_funct3[2];
              off_q    <= i_lsu_addr[1:0];
              wdata_q  <= st_wdata;
              bmask_q  <= st_bmask;
              err_q    <= 1'b0;
              wait_cnt <= '0;
            end else begin
              err_q    <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // A late ack still completes the access even on the timeout cycle.
          if (mem.i_mem_ack) begin
            if (!we_q) ld_data_q <= ld_ext;
          end else if (timeout) begin
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Busy is gated by reset so every output is zero while reset is held.
  assign o_lsu_busy      = busy_c & i_rst_n;
  assign o_ld_valid      = (state == RESP) & ~err_q & ~we_q;
  assign o_lsu_err       = (state == RESP) & err_q;
  assign o_ld_data       = ld_data_q;
  assign mem.o_mem_req   = (state == ACCESS);
  assign mem.o_mem_we    = we_q;
  assign mem.o_mem_addr  = {addr_q, 2'b00};
  assign mem.o_mem_wdata = wdata_q;
  assign mem.o_mem_bmask = bmask_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed vector table, reset-in-flight sequence,
// and random operations against a behavioural reference model.
module tb_lsu_mem_ctrl;
  localparam int unsigned MW = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req, lsu_wren;
  logic [2:0]  funct3;
  logic [31:0] lsu_addr, st_data;
  logic        lsu_busy, ld_valid, lsu_err;
  logic [31:0] ld_data;

  lsu_mem_ctrl_if bus();

  lsu_mem_ctrl #(.MAX_WAIT(MW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_lsu_req  (lsu_req),
    .i_lsu_wren (lsu_wren),
    .i_funct3   (funct3),
    .i_lsu_addr (lsu_addr),
    .i_st_data  (st_data),
    .o_lsu_busy (lsu_busy),
    .o_ld_valid (ld_valid),
    .o_ld_data  (ld_data),
    .o_lsu_err  (lsu_err),
    .mem        (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mdl_ld;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rd;
    int          waits;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_bmask;
    logic [31:0] exp_wdata;
    int          exp_reqc;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: what one request should produce, from the architectural rules.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] sd, input logic [31:0] rd, input int waits,
                                output logic err, output logic [31:0] data, output logic [31:0] maddr,
                                output logic [31:0] wdata, output logic [3:0] bm, output int reqc);
    int nbytes;
    int off;
    logic okf;
    logic [31:0] v;
    off    = int'(addr % 4);
    okf    = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5) && !(we && f3[2]);
    nbytes = okf ? (1 << f3[1:0]) : 1;
    err    = !okf || ((addr % nbytes) != 0);
    maddr  = addr & 32'hFFFF_FFFC;
    bm     = we ? 4'(((1 << nbytes) - 1) << off) : 4'hF;
    wdata  = (nbytes == 1) ? {24'h0, sd[7:0]} * 32'h0101_0101 :
             (nbytes == 2) ? {16'h0, sd[15:0]} * 32'h0001_0001 : sd;
    data   = mdl_ld;
    if (err) begin
      reqc = 0;
    end else if (waits >= int'(MW)) begin
      err  = 1'b1;
      reqc = int'(MW);
    end else begin
      reqc = waits + 1;
      if (!we) begin
        v = rd >> (8 * off);
        if (nbytes == 1) begin
          v = v & 32'hFF;
          if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (nbytes == 2) begin
          v = v & 32'hFFFF;
          if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        data = v;
      end
    end
  endfunction

  task automatic run_op(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] rd, input int waits,
                        input logic exp_err, input logic [31:0] exp_data, input logic [31:0] exp_maddr,
                        input logic [3:0] exp_bmask, input logic [31:0] exp_wdata, input int exp_reqc);
    int reqc;
    logic done;
    @(negedge clk);
    lsu_req = 1'b1; lsu_wren = we; funct3 = f3; lsu_addr = addr; st_data = sd;
    bus.i_mem_ack = 1'b0;
    #1;
    chk($sformatf("%s.busy_req", tag), 32'(lsu_busy), 32'd1);
    reqc = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < int'(MW) + 8 && !done; cyc++) begin
      @(posedge clk); #1;
      if (bus.o_mem_req) begin
        reqc++;
        if (reqc == 1) begin
          chk($sformatf("%s.busy_acc", tag), 32'(lsu_busy), 32'd1);
          chk($sformatf("%s.maddr", tag), bus.o_mem_addr, exp_maddr);
          chk($sformatf("%s.we", tag), 32'(bus.o_mem_we), 32'(we));
          chk($sformatf("%s.bmask", tag), 32'(bus.o_mem_bmask), 32'(exp_bmask));
          if (we) chk($sformatf("%s.wdata", tag), bus.o_mem_wdata, exp_wdata);
        end
        bus.i_mem_ack   = (reqc == waits + 1);
        bus.i_mem_rdata = bus.i_mem_ack ? rd : $urandom;
      end else begin
        done = 1'b1;
        bus.i_mem_ack = 1'b0;
        chk($sformatf("%s.ld_valid", tag), 32'(ld_valid), 32'(!exp_err && !we));
        chk($sformatf("%s.err", tag), 32'(lsu_err), 32'(exp_err));
        chk($sformatf("%s.ld_data", tag), ld_data, exp_data);
        chk($sformatf("%s.busy_resp", tag), 32'(lsu_busy), 32'd0);
        chk($sformatf("%s.req_cycles", tag), 32'(reqc), 32'(exp_reqc));
        lsu_req = 1'b0;
      end
    end
    if (!done) begin
      chk($sformatf("%s.completion_timeout", tag), 32'd0, 32'd1);
      lsu_req = 1'b0;
    end
    @(posedge clk); #1;
    chk($sformatf("%s.pulse_end", tag), {29'd0, ld_valid, lsu_err, lsu_busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    logic e;
    logic [31:0] d, ma, wd;
    logic [3:0] bm;
    int rc;
    logic rwe;
    logic [2:0] rf3;
    logic [31:0] raddr, rsd, rrd;
    int rwaits;

    tbl[0]  = '{1'b0, 3'b000, 32'h103, 32'h0,         32'h80FF_1234, 0,  1'b0, 32'hFFFF_FF80, 32'h100, 4'hF, 32'h0,         1};
    tbl[1]  = '{1'b0, 3'b101, 32'h102, 32'h0,         32'h8001_0000, 3,  1'b0, 32'h0000_8001, 32'h100, 4'hF, 32'h0,         4};
    tbl[2]  = '{1'b1, 3'b000, 32'h021, 32'h1234_56AB, 32'h0,         0,  1'b0, 32'h0000_8001, 32'h020, 4'h2, 32'hABAB_ABAB, 1};
    tbl[3]  = '{1'b0, 3'b010, 32'h102, 32'h0,         32'h0,         0,  1'b1, 32'h0000_8001, 32'h100, 4'hF, 32'h0,         0};
    tbl[4]  = '{1'b0, 3'b011, 32'h100, 32'h0,         32'h0,         0,  1'b1, 32'h0000_8001, 32'h100, 4'hF, 32'h0,         0};
    tbl[5]  = '{1'b0, 3'b010, 32'h200, 32'h0,         32'h1122_3344, 20, 1'b1, 32'h0000_8001, 32'h200, 4'hF, 32'h0,         16};
    tbl[6]  = '{1'b0, 3'b001, 32'h202, 32'h0,         32'h8001_7FFF, 15, 1'b0, 32'hFFFF_8001, 32'h200, 4'hF, 32'h0,         16};
    tbl[7]  = '{1'b1, 3'b001, 32'h046, 32'hCAFE_BEEF, 32'h0,         1,  1'b0, 32'hFFFF_8001, 32'h044, 4'hC, 32'hBEEF_BEEF, 2};
    tbl[8]  = '{1'b1, 3'b010, 32'h048, 32'h0102_0304, 32'h0,         0,  1'b0, 32'hFFFF_8001, 32'h048, 4'hF, 32'h0102_0304, 1};
    tbl[9]  = '{1'b1, 3'b100, 32'h050, 32'h55,        32'h0,         0,  1'b1, 32'hFFFF_8001, 32'h050, 4'h1, 32'h0,         0};
    tbl[10] = '{1'b0, 3'b100, 32'h301, 32'h0,         32'h0000_9A00, 0,  1'b0, 32'h0000_009A, 32'h300, 4'hF, 32'h0,         1};
    tbl[11] = '{1'b0, 3'b001, 32'h101, 32'h0,         32'h0,         0,  1'b1, 32'h0000_009A, 32'h100, 4'hF, 32'h0,         0};
    tbl[12] = '{1'b0, 3'b000, 32'h100, 32'h0,         32'h0000_007F, 2,  1'b0, 32'h0000_007F, 32'h100, 4'hF, 32'h0,         3};

    rst_n = 1'b0; lsu_req = 1'b0; lsu_wren = 1'b0; funct3 = '0; lsu_addr = '0; st_data = '0;
    bus.i_mem_ack = 1'b0; bus.i_mem_rdata = '0;
    mdl_ld = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.ctl", {27'd0, bus.o_mem_req, bus.o_mem_we, lsu_busy, ld_valid, lsu_err}, 32'd0);
    chk("reset.ld_data", ld_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].sd, tbl[i].rd, tbl[i].waits,
             tbl[i].exp_err, tbl[i].exp_data, tbl[i].exp_maddr, tbl[i].exp_bmask, tbl[i].exp_wdata,
             tbl[i].exp_reqc);
      mdl_ld = tbl[i].exp_data;
    end

    // Reset asserted in the second ACCESS cycle of a load.
    @(negedge clk);
    lsu_req = 1'b1; lsu_wren = 1'b0; funct3 = 3'b010; lsu_addr = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid.in_access", 32'(bus.o_mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.ctl", {27'd0, bus.o_mem_req, bus.o_mem_we, lsu_busy, ld_valid, lsu_err}, 32'd0);
    chk("rst_mid.ld_data", ld_data, 32'd0);
    chk("rst_mid.bus", bus.o_mem_addr | bus.o_mem_wdata | {28'd0, bus.o_mem_bmask}, 32'd0);
    mdl_ld = '0;
    @(negedge clk); lsu_req = 1'b0; rst_n = 1'b1;
    run_op("post_rst_lw", 1'b0, 3'b010, 32'h0, 32'h0, 32'hDEAD_BEEF, 0,
           1'b0, 32'hDEAD_BEEF, 32'h0, 4'hF, 32'h0, 1);
    mdl_ld = 32'hDEAD_BEEF;

    for (int i = 0; i < 60; i++) begin
      rwe = ($urandom % 3) == 0;
      if (($urandom % 4) != 0) begin
        case ($urandom % 5)
          0: rf3 = 3'b000;
          1: rf3 = 3'b001;
          2: rf3 = 3'b010;
          3: rf3 = 3'b100;
          default: rf3 = 3'b101;
        endcase
      end else begin
        rf3 = 3'($urandom);
      end
      raddr  = $urandom;
      if (($urandom % 3) != 0) raddr = raddr & ~(32'((1 << rf3[1:0]) - 1));
      rsd    = $urandom;
      rrd    = $urandom;
      rwaits = (($urandom % 10) == 0) ? int'(MW) + 2 : int'($urandom % 4);
      model(rwe, rf3, raddr, rsd, rrd, rwaits, e, d, ma, wd, bm, rc);
      run_op($sformatf("rnd%0d", i), rwe, rf3, raddr, rsd, rrd, rwaits, e, d, ma, bm, wd, rc);
      mdl_ld = d;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
